// File: rtl/ahb3lite_cmd_master_if.sv
// Bundle of the command/response handshake and the AHB3-Lite bus seen by ahb3lite_cmd_master.
// The master modport is the controller's view; the slave modport is the environment's view.
interface ahb3lite_cmd_master_if #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [HADDR_SIZE-1:0] cmd_addr;
    logic                  cmd_write;
    logic [2:0]            cmd_size;
    logic [HDATA_SIZE-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [HDATA_SIZE-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, rsp_ready,
        input  HRDATA, HREADYOUT, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata, rsp_ready,
        output HRDATA, HREADYOUT, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY
    );
endinterface

// File: rtl/ahb3lite_cmd_master.sv
// Single-outstanding AHB3-Lite master: turns valid/ready read/write commands into SINGLE NONSEQ
// transfers and returns read data / error status on a valid/ready response port.
module ahb3lite_cmd_master #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahb3lite_cmd_master_if.master  bus
);
    localparam int MAX_SIZE = $clog2(HDATA_SIZE / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                state, state_nx;
    logic                  armed;
    logic                  hsel, hsel_nx;
    logic [1:0]            htrans, htrans_nx;
    logic [HADDR_SIZE-1:0] haddr, haddr_nx;
    logic [HDATA_SIZE-1:0] hwdata, hwdata_nx;
    logic                  hwrite, hwrite_nx;
    logic [2:0]            hsize, hsize_nx;
    logic                  write_q, write_nx;
    logic [HDATA_SIZE-1:0] wdata_q, wdata_nx;
    logic                  rsp_valid, rsp_valid_nx;
    logic [HDATA_SIZE-1:0] rsp_rdata, rsp_rdata_nx;
    logic                  rsp_err, rsp_err_nx;
    logic                  cmd_ready;

    // A command is legal when its size fits the data bus and the address is size-aligned.
    function automatic logic cmd_legal(input logic [HADDR_SIZE-1:0] addr, input logic [2:0] size);
        logic ok;
        ok = (int'(size) <= MAX_SIZE);
        for (int i = 0; i < MAX_SIZE; i++) begin
            if (i < int'(size) && addr[i]) ok = 1'b0;
        end
        return ok;
    endfunction

    // armed keeps cmd_ready low until the first clock edge after reset release.
    assign cmd_ready = armed && (state == IDLE);

    always_comb begin
        state_nx     = state;
        hsel_nx      = hsel;
        htrans_nx    = htrans;
        haddr_nx     = haddr;
        hwdata_nx    = hwdata;
        hwrite_nx    = hwrite;
        hsize_nx     = hsize;
        write_nx     = write_q;
        wdata_nx     = wdata_q;
        rsp_valid_nx = rsp_valid;
        rsp_rdata_nx = rsp_rdata;
        rsp_err_nx   = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_ready && bus.cmd_valid) begin
                    write_nx = bus.cmd_write;
                    wdata_nx = bus.cmd_wdata;
                    if (cmd_legal(bus.cmd_addr, bus.cmd_size)) begin
                        state_nx  = ADDR;
                        hsel_nx   = 1'b1;
                        htrans_nx = 2'b10;
                        haddr_nx  = bus.cmd_addr;
                        hwrite_nx = bus.cmd_write;
                        hsize_nx  = bus.cmd_size;
                    end else begin
                        state_nx     = RESP;
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = '0;
                    end
                end
            end
            ADDR: begin
                if (bus.HREADYOUT) begin
                    state_nx  = DATA;
                    hsel_nx   = 1'b0;
                    htrans_nx = 2'b00;
                    if (write_q) hwdata_nx = wdata_q;
                end
            end
            DATA: begin
                // Wait states and the first error cycle both keep us here with HWDATA held.
                if (bus.HREADYOUT) begin
                    state_nx     = RESP;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = bus.HRESP;
                    rsp_rdata_nx = (!write_q && !bus.HRESP) ? bus.HRDATA : '0;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx     = IDLE;
                    rsp_valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            armed     <= 1'b0;
            hsel      <= 1'b0;
            htrans    <= 2'b00;
            haddr     <= '0;
            hwdata    <= '0;
            hwrite    <= 1'b0;
            hsize     <= 3'b000;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            armed     <= 1'b1;
            hsel      <= hsel_nx;
            htrans    <= htrans_nx;
            haddr     <= haddr_nx;
            hwdata    <= hwdata_nx;
            hwrite    <= hwrite_nx;
            hsize     <= hsize_nx;
            write_q   <= write_nx;
            wdata_q   <= wdata_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rsp_rdata_nx;
            rsp_err   <= rsp_err_nx;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.HSEL      = hsel;
    assign bus.HTRANS    = htrans;
    assign bus.HADDR     = haddr;
    assign bus.HWDATA    = hwdata;
    assign bus.HWRITE    = hwrite;
    assign bus.HSIZE     = hsize;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HREADY    = bus.HREADYOUT;
endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Directed bench for ahb3lite_cmd_master: behavioural memory slave with wait/error injection,
// response scoreboard, and inline bus-timing checks.
module tb_ahb3lite_cmd_master;
    localparam int AW = 16;
    localparam int DW = 32;

    logic HCLK;
    logic HRESETn;

    ahb3lite_cmd_master_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus ();

    ahb3lite_cmd_master #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   rsp_cnt = 0;
    int   nonseq_cnt = 0;
    int   wait_n = 0;
    logic err_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave model: word memory, optional wait states or two-cycle ERROR response.
    logic [DW-1:0] mem [0:63];
    logic          dph = 1'b0;
    logic          d_write = 1'b0;
    logic [5:0]    d_idx = '0;
    int            cnt = 0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph           <= 1'b0;
            cnt           <= 0;
            bus.HREADYOUT <= 1'b1;
            bus.HRESP     <= 1'b0;
            bus.HRDATA    <= '0;
        end else begin
            if (dph && bus.HREADYOUT) begin
                if (d_write && !bus.HRESP) mem[d_idx] <= bus.HWDATA;
                dph       <= 1'b0;
                bus.HRESP <= 1'b0;
            end else if (dph) begin
                if (cnt > 1) cnt <= cnt - 1;
                else bus.HREADYOUT <= 1'b1;
            end
            if (bus.HSEL && bus.HTRANS == 2'b10 && bus.HREADY) begin
                nonseq_cnt <= nonseq_cnt + 1;
                dph        <= 1'b1;
                d_write    <= bus.HWRITE;
                d_idx      <= bus.HADDR[7:2];
                bus.HRDATA <= bus.HWRITE ? '0 : mem[bus.HADDR[7:2]];
                if (err_mode) begin
                    bus.HREADYOUT <= 1'b0;
                    bus.HRESP     <= 1'b1;
                    cnt           <= 1;
                end else if (wait_n != 0) begin
                    bus.HREADYOUT <= 1'b0;
                    cnt           <= wait_n;
                end
            end
        end
    end

    // Response monitor: every consumed response is compared against the scoreboard head.
    always @(negedge HCLK) begin
        if (HRESETn && bus.rsp_valid && bus.rsp_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            end
            rsp_cnt++;
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] addr, input logic wr, input logic [2:0] size,
                        input logic [DW-1:0] wdata);
        logic acc;
        acc           = 1'b0;
        bus.cmd_addr  = addr;
        bus.cmd_write = wr;
        bus.cmd_size  = size;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge HCLK);
            acc = bus.cmd_ready;
            @(posedge HCLK);
            #1;
        end
        bus.cmd_valid = 1'b0;
        check("cmd_accept", 64'(acc), 64'd1);
    endtask

    task automatic push(input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 50 && rsp_cnt < target; i++) step();
        check("rsp_arrived", 64'(rsp_cnt >= target), 64'd1);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hsel"}, 64'(bus.HSEL), 64'd0);
        check({tag, "_htrans"}, 64'(bus.HTRANS), 64'd0);
        check({tag, "_haddr"}, 64'(bus.HADDR), 64'd0);
        check({tag, "_hwdata"}, 64'(bus.HWDATA), 64'd0);
        check({tag, "_hwrite"}, 64'(bus.HWRITE), 64'd0);
        check({tag, "_hsize"}, 64'(bus.HSIZE), 64'd0);
        check({tag, "_hburst"}, 64'(bus.HBURST), 64'd0);
        check({tag, "_hprot"}, 64'(bus.HPROT), 64'h3);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        check({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        HRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_size  = 3'd0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge HCLK);
        #2;
        check_reset_outputs("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
        check("ready_before_edge", 64'(bus.cmd_ready), 64'd0);
        step();
        check("ready_after_release", 64'(bus.cmd_ready), 64'd1);

        // Zero-wait word write
        push('0, 1'b0);
        send(16'h0010, 1'b1, 3'd2, 32'hDEADBEEF);
        check("wr_htrans_nonseq", 64'(bus.HTRANS), 64'h2);
        check("wr_hsel", 64'(bus.HSEL), 64'd1);
        check("wr_haddr", 64'(bus.HADDR), 64'h0010);
        check("wr_hwrite", 64'(bus.HWRITE), 64'd1);
        check("wr_hsize", 64'(bus.HSIZE), 64'd2);
        check("wr_hburst", 64'(bus.HBURST), 64'd0);
        check("wr_cmd_ready_busy", 64'(bus.cmd_ready), 64'd0);
        step();
        check("wr_data_htrans", 64'(bus.HTRANS), 64'd0);
        check("wr_hwdata", 64'(bus.HWDATA), 64'hDEADBEEF);
        check("wr_rsp_early", 64'(bus.rsp_valid), 64'd0);
        step();
        check("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        wait_rsp(1);

        // Word, halfword and byte reads return the full bus word unmasked
        push(32'hDEADBEEF, 1'b0);
        send(16'h0010, 1'b0, 3'd2, '0);
        wait_rsp(2);
        push(32'hDEADBEEF, 1'b0);
        send(16'h0011, 1'b0, 3'd0, '0);
        check("byte_haddr", 64'(bus.HADDR), 64'h0011);
        wait_rsp(3);
        push(32'hDEADBEEF, 1'b0);
        send(16'h0012, 1'b0, 3'd1, '0);
        wait_rsp(4);

        // Three data-phase wait states on a write
        wait_n = 3;
        push('0, 1'b0);
        send(16'h0020, 1'b1, 3'd2, 32'h12345678);
        step();
        for (int k = 0; k < 3; k++) begin
            check("ws_hreadyout_low", 64'(bus.HREADY), 64'd0);
            check("ws_hwdata_stable", 64'(bus.HWDATA), 64'h12345678);
            check("ws_htrans_idle", 64'(bus.HTRANS), 64'd0);
            check("ws_no_rsp", 64'(bus.rsp_valid), 64'd0);
            step();
        end
        check("ws_last_hwdata", 64'(bus.HWDATA), 64'h12345678);
        check("ws_last_no_rsp", 64'(bus.rsp_valid), 64'd0);
        step();
        check("ws_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        wait_rsp(5);
        wait_n = 0;
        push(32'h12345678, 1'b0);
        send(16'h0020, 1'b0, 3'd2, '0);
        wait_rsp(6);

        // Two-cycle ERROR response on a read
        err_mode = 1'b1;
        n0 = nonseq_cnt;
        push('0, 1'b1);
        send(16'h0010, 1'b0, 3'd2, '0);
        step();
        check("err_cycle1_rsp", 64'(bus.rsp_valid), 64'd0);
        step();
        check("err_cycle2_rsp", 64'(bus.rsp_valid), 64'd0);
        step();
        check("err_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        err_mode = 1'b0;
        wait_rsp(7);
        repeat (3) step();
        check("err_no_retry", 64'(nonseq_cnt - n0), 64'd1);

        // Illegal commands: misaligned word and oversize
        n0 = nonseq_cnt;
        push('0, 1'b1);
        send(16'h0002, 1'b0, 3'd2, '0);
        check("misalign_htrans", 64'(bus.HTRANS), 64'd0);
        check("misalign_hsel", 64'(bus.HSEL), 64'd0);
        check("misalign_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        wait_rsp(8);
        push('0, 1'b1);
        send(16'h0000, 1'b1, 3'd3, 32'hFFFF_FFFF);
        check("oversize_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("oversize_htrans", 64'(bus.HTRANS), 64'd0);
        wait_rsp(9);
        check("illegal_no_nonseq", 64'(nonseq_cnt - n0), 64'd0);

        // Response back-pressure
        bus.rsp_ready = 1'b0;
        push(32'hDEADBEEF, 1'b0);
        send(16'h0010, 1'b0, 3'd2, '0);
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) step();
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
            check("bp_rsp_err", 64'(bus.rsp_err), 64'd0);
            check("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        wait_rsp(10);

        // Reset in the middle of a data phase
        wait_n = 3;
        send(16'h0040, 1'b1, 3'd2, 32'hCAFEF00D);
        step();
        check("mid_in_data", 64'(bus.HWDATA), 64'hCAFEF00D);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        wait_n = 0;
        HRESETn = 1'b1;
        #1;
        check("midrst_ready_before_edge", 64'(bus.cmd_ready), 64'd0);
        step();
        check("midrst_ready_after", 64'(bus.cmd_ready), 64'd1);
        check("midrst_rsp_discarded", 64'(bus.rsp_valid), 64'd0);

        push(32'h12345678, 1'b0);
        send(16'h0020, 1'b0, 3'd2, '0);
        wait_rsp(11);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
